instr_issue_queue: RTL

//   Producer side of the 9-bit instruction interface consumed by control_unit.

---
 rtl/instr_issue_queue.sv | 90 +++++++++
 1 files changed

// File: rtl/instr_issue_queue.sv
// rtl/instr_issue_queue.sv - instruction issue queue packing decoded fields into a FWFT FIFO
module instr_issue_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic [2:0]                 i_req_op,
    input  logic [2:0]                 i_req_dest,
    input  logic [2:0]                 i_req_src,
    output logic [8:0]                 o_instruction,
    output logic                       o_instr_valid,
    input  logic                       i_instr_ready,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic [CNT_W-1:0]           o_issued_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    logic [8:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [CNT_W-1:0] r_issued_count;

    logic       w_req_ready;
    logic       w_instr_valid;
    logic       w_push;
    logic       w_pop;
    logic [8:0] w_packed;

    // Handshake qualifiers; both come only from registered occupancy, so a pop
    // never frees a slot for a push in the same cycle.
    always_comb begin
        w_req_ready   = (r_level != FULL_LEVEL);
        w_instr_valid = (r_level != '0);
        w_push        = i_req_valid & w_req_ready & ~i_flush & ~i_rst;
        w_pop         = w_instr_valid & i_instr_ready & ~i_flush & ~i_rst;
        w_packed      = {i_req_op, i_req_dest, i_req_src};
    end

    // Entry storage; contents are never reset, occupancy tracking guards reads.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_packed;
        end
    end

    // Pointer, occupancy and issue counter update; reset beats flush beats traffic.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_issued_count <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr       <= r_rd_ptr + PTR_W'(1);
                r_issued_count <= r_issued_count + CNT_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    // Head presentation: first-word-fall-through, zero when nothing is queued.
    always_comb begin
        o_req_ready    = w_req_ready;
        o_instr_valid  = w_instr_valid;
        o_instruction  = w_instr_valid ? r_mem[r_rd_ptr] : 9'h000;
        o_level        = r_level;
        o_issued_count = r_issued_count;
    end

endmodule
